// File: rtl/proc_sched_pkg.sv
// Shared types and constants for the preemptive quantum scheduler.
package proc_sched_pkg;

   localparam int unsigned NPROC   = 8;
   localparam int unsigned PIDW    = $clog2(NPROC);
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      RUN,
      SAVE
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first active slot strictly after cur_pid, wrapping NPROC-1 -> 0.
// The last candidate visited is cur_pid itself, so a lone active slot is re-picked.
module rr_arbiter #(
   parameter int unsigned NPROC = proc_sched_pkg::NPROC,
   parameter int unsigned PIDW  = $clog2(NPROC)
) (
   input  logic [NPROC-1:0] active,
   input  logic [PIDW-1:0]  cur_pid,
   output logic [PIDW-1:0]  next_pid,
   output logic             any_active
);

   logic            found;
   logic [PIDW-1:0] idx;

   // Rotate-and-priority-encode; the PIDW-bit add wraps for free (NPROC is a power of 2).
   always_comb begin
      next_pid   = cur_pid;
      any_active = |active;
      found      = 1'b0;
      idx        = '0;
      for (int i = 1; i <= int'(NPROC); i++) begin
         idx = cur_pid + PIDW'(i);
         if (!found && active[idx]) begin
            next_pid = idx;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive round-robin quantum scheduler beside the MIPS core.
// Counts retired instructions per quantum, saves the resume PC on expiry,
// requests a context change and then dispatches the next active process.
// Optional: define QUANTUM_STATS_EN for per-slot saturating preemption counters.
module quantum_scheduler
   import proc_sched_pkg::*;
#(
   parameter int unsigned NPROC    = proc_sched_pkg::NPROC,
   parameter int unsigned PIDW     = $clog2(NPROC),
   parameter int unsigned QW       = 32,
   parameter int unsigned QDEFAULT = 1000
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            tick,
   input  logic            halt,
   input  logic            set_quantum,
   input  logic [QW-1:0]   quantum_value,
   input  logic            proc_start,
   input  logic [PIDW-1:0] start_pid,
   input  logic [31:0]     start_pc,
   input  logic            proc_end,
   input  logic [31:0]     pc_in,
   input  logic            ctx_ack,
`ifdef QUANTUM_STATS_EN
   input  logic [PIDW-1:0] stat_pid,
   output logic [15:0]     stat_cnt,
`endif
   output logic            preempt_req,
   output logic            dispatch_vld,
   output logic [PIDW-1:0] next_pid,
   output logic [31:0]     next_pc,
   output logic [PIDW-1:0] cur_pid,
   output logic            os_mode,
   output logic [QW-1:0]   quantum_left
);

   sched_state_t    state_q, state_d;
   logic [NPROC-1:0] active_q, active_d;
   logic [NPROC-1:0] start_mask, end_mask;
   logic [31:0]     pc_tab_q [NPROC];
   logic [31:0]     pc_tab_d [NPROC];
   logic [QW-1:0]   quantum_q, quantum_d;
   logic [QW-1:0]   quantum_left_q, quantum_left_d;
   logic [PIDW-1:0] cur_pid_q, cur_pid_d;
   logic [PIDW-1:0] next_pid_q, next_pid_d;
   logic [31:0]     next_pc_q, next_pc_d;
   logic            dispatch_vld_q, dispatch_vld_d;
   logic            preempt_req_q, preempt_req_d;
   logic            os_mode_q, os_mode_d;
   logic [PIDW-1:0] rr_pid;
   logic            rr_any;
   logic            end_now;
   logic            expire;

   rr_arbiter #(
      .NPROC (NPROC),
      .PIDW  (PIDW)
   ) u_rr_arbiter (
      .active     (active_q),
      .cur_pid    (cur_pid_q),
      .next_pid   (rr_pid),
      .any_active (rr_any)
   );

   // proc_end only counts while a process owns the core; an end beats a same-cycle expiry.
   assign end_now = proc_end && (state_q == RUN || state_q == SAVE);
   assign expire  = (state_q == RUN) && !proc_end && tick && !halt &&
                    (quantum_left_q == QW'(1));

   // Slot set/clear masks; start is ORed in last so it wins over a same-slot end.
   always_comb begin
      start_mask = '0;
      end_mask   = '0;
      if (proc_start) start_mask[start_pid] = 1'b1;
      if (end_now)    end_mask[cur_pid_q]   = 1'b1;
   end

   // Next-state logic: table updates, quantum counting and the scheduling FSM.
   always_comb begin
      state_d        = state_q;
      active_d       = (active_q & ~end_mask) | start_mask;
      pc_tab_d       = pc_tab_q;
      quantum_d      = quantum_q;
      quantum_left_d = quantum_left_q;
      cur_pid_d      = cur_pid_q;
      next_pid_d     = next_pid_q;
      next_pc_d      = next_pc_q;
      dispatch_vld_d = 1'b0;
      preempt_req_d  = preempt_req_q;
      os_mode_d      = os_mode_q;

      if (set_quantum) quantum_d = quantum_value;
      if (expire)      pc_tab_d[cur_pid_q] = pc_in + PC_STEP;
      if (proc_start)  pc_tab_d[start_pid] = start_pc;

      unique case (state_q)
         IDLE: begin
            os_mode_d = 1'b1;
            if (rr_any && !halt) state_d = DISPATCH;
         end
         DISPATCH: begin
            if (!halt) begin
               if (rr_any) begin
                  dispatch_vld_d = 1'b1;
                  next_pid_d     = rr_pid;
                  next_pc_d      = pc_tab_q[rr_pid];
                  cur_pid_d      = rr_pid;
                  quantum_left_d = quantum_q;
                  os_mode_d      = 1'b0;
                  state_d        = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RUN, SAVE: begin
            if (end_now) begin
               preempt_req_d = 1'b0;
               if (|active_d) begin
                  state_d = DISPATCH;
               end else begin
                  state_d   = IDLE;
                  os_mode_d = 1'b1;
               end
            end else if (state_q == RUN) begin
               // A zero quantum never counts down, so it never expires.
               if (tick && !halt && quantum_left_q != '0) begin
                  quantum_left_d = quantum_left_q - QW'(1);
                  if (expire) begin
                     preempt_req_d = 1'b1;
                     state_d       = SAVE;
                  end
               end
            end else if (ctx_ack) begin
               preempt_req_d = 1'b0;
               state_d       = DISPATCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         active_q       <= '0;
         for (int i = 0; i < int'(NPROC); i++) pc_tab_q[i] <= '0;
         quantum_q      <= QW'(QDEFAULT);
         quantum_left_q <= '0;
         cur_pid_q      <= '0;
         next_pid_q     <= '0;
         next_pc_q      <= '0;
         dispatch_vld_q <= 1'b0;
         preempt_req_q  <= 1'b0;
         os_mode_q      <= 1'b1;
      end else begin
         state_q        <= state_d;
         active_q       <= active_d;
         pc_tab_q       <= pc_tab_d;
         quantum_q      <= quantum_d;
         quantum_left_q <= quantum_left_d;
         cur_pid_q      <= cur_pid_d;
         next_pid_q     <= next_pid_d;
         next_pc_q      <= next_pc_d;
         dispatch_vld_q <= dispatch_vld_d;
         preempt_req_q  <= preempt_req_d;
         os_mode_q      <= os_mode_d;
      end
   end

`ifdef QUANTUM_STATS_EN
   logic [15:0] stat_q [NPROC];
   logic [15:0] stat_d [NPROC];

   // Saturating per-slot preemption count; a (re)start clears the slot's count.
   always_comb begin
      stat_d = stat_q;
      if (expire && stat_q[cur_pid_q] != 16'hFFFF) begin
         stat_d[cur_pid_q] = stat_q[cur_pid_q] + 16'd1;
      end
      if (proc_start) stat_d[start_pid] = '0;
   end

   // Preemption counter registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NPROC); i++) stat_q[i] <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_cnt = stat_q[stat_pid];
`endif

   assign preempt_req  = preempt_req_q;
   assign dispatch_vld = dispatch_vld_q;
   assign next_pid     = next_pid_q;
   assign next_pc      = next_pc_q;
   assign cur_pid      = cur_pid_q;
   assign os_mode      = os_mode_q;
   assign quantum_left = quantum_left_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed self-checking bench for quantum_scheduler (default NPROC=8, QW=32).
module tb_quantum_scheduler;

   localparam int PIDW = 3;
   localparam int QW   = 32;

   logic            CLK = 1'b0;
   logic            reset = 1'b0;
   logic            tick = 1'b0;
   logic            halt = 1'b0;
   logic            set_quantum = 1'b0;
   logic [QW-1:0]   quantum_value = '0;
   logic            proc_start = 1'b0;
   logic [PIDW-1:0] start_pid = '0;
   logic [31:0]     start_pc = '0;
   logic            proc_end = 1'b0;
   logic [31:0]     pc_in = '0;
   logic            ctx_ack = 1'b0;
   logic            preempt_req;
   logic            dispatch_vld;
   logic [PIDW-1:0] next_pid;
   logic [31:0]     next_pc;
   logic [PIDW-1:0] cur_pid;
   logic            os_mode;
   logic [QW-1:0]   quantum_left;
`ifdef QUANTUM_STATS_EN
   logic [PIDW-1:0] stat_pid = '0;
   logic [15:0]     stat_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   quantum_scheduler u_dut (
      .CLK           (CLK),
      .reset         (reset),
      .tick          (tick),
      .halt          (halt),
      .set_quantum   (set_quantum),
      .quantum_value (quantum_value),
      .proc_start    (proc_start),
      .start_pid     (start_pid),
      .start_pc      (start_pc),
      .proc_end      (proc_end),
      .pc_in         (pc_in),
      .ctx_ack       (ctx_ack),
`ifdef QUANTUM_STATS_EN
      .stat_pid      (stat_pid),
      .stat_cnt      (stat_cnt),
`endif
      .preempt_req   (preempt_req),
      .dispatch_vld  (dispatch_vld),
      .next_pid      (next_pid),
      .next_pc       (next_pc),
      .cur_pid       (cur_pid),
      .os_mode       (os_mode),
      .quantum_left  (quantum_left)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_dispatch(input int budget);
      int n = 0;
      while (!dispatch_vld && n < budget) begin
         step();
         n++;
      end
      check_eq("dispatch_seen", 64'(dispatch_vld), 64'd1);
   endtask

   task automatic check_disp(input string tag, input logic [PIDW-1:0] pid, input logic [31:0] pc);
      check_eq({tag, "_pid"}, 64'(next_pid), 64'(pid));
      check_eq({tag, "_pc"}, 64'(next_pc), 64'(pc));
      check_eq({tag, "_cur"}, 64'(cur_pid), 64'(pid));
   endtask

   // Run n expiring ticks with the given core PC, acknowledge, and wait for the next dispatch.
   task automatic run_expiry(input int n, input logic [31:0] pc);
      pc_in = pc;
      tick  = 1'b1;
      for (int i = 1; i <= n; i++) begin
         step();
         if (i < n) check_eq("early_preempt", 64'(preempt_req), 64'd0);
      end
      tick = 1'b0;
      check_eq("expiry_preempt", 64'(preempt_req), 64'd1);
      check_eq("expiry_qleft", 64'(quantum_left), 64'd0);
      step();
      check_eq("hold_preempt", 64'(preempt_req), 64'd1);
      ctx_ack = 1'b1;
      step();
      ctx_ack = 1'b0;
      check_eq("ack_clears", 64'(preempt_req), 64'd0);
      wait_dispatch(4);
   endtask

   task automatic start_slot(input logic [PIDW-1:0] pid, input logic [31:0] pc);
      proc_start = 1'b1;
      start_pid  = pid;
      start_pc   = pc;
      step();
      proc_start = 1'b0;
   endtask

   initial begin
      logic seen;

      // Reset values
      step();
      step();
      check_eq("rst_preempt", 64'(preempt_req), 64'd0);
      check_eq("rst_dispatch", 64'(dispatch_vld), 64'd0);
      check_eq("rst_next_pid", 64'(next_pid), 64'd0);
      check_eq("rst_next_pc", 64'(next_pc), 64'd0);
      check_eq("rst_cur_pid", 64'(cur_pid), 64'd0);
      check_eq("rst_os_mode", 64'(os_mode), 64'd1);
      check_eq("rst_qleft", 64'(quantum_left), 64'd0);
      reset = 1'b1;
      step();

      // 1: single process, quantum 3, re-dispatch with saved PC
      set_quantum   = 1'b1;
      quantum_value = 32'd3;
      start_slot(3'd2, 32'h100);
      set_quantum = 1'b0;
      check_eq("idle_os_mode", 64'(os_mode), 64'd1);
      wait_dispatch(4);
      check_disp("first", 3'd2, 32'h100);
      check_eq("first_qleft", 64'(quantum_left), 64'd3);
      check_eq("first_os_mode", 64'(os_mode), 64'd0);
      run_expiry(3, 32'h200);
      check_disp("redispatch", 3'd2, 32'h204);

      // 2: slots 0,5,7 with wrap-around
      start_slot(3'd0, 32'h1000);
      start_slot(3'd5, 32'h5000);
      start_slot(3'd7, 32'h7000);
      proc_end = 1'b1;
      step();
      proc_end = 1'b0;
      wait_dispatch(4);
      check_disp("after_end2", 3'd5, 32'h5000);
      run_expiry(3, 32'h5A00);
      check_disp("rr_5_to_7", 3'd7, 32'h7000);
      run_expiry(3, 32'h7B00);
      check_disp("rr_wrap", 3'd0, 32'h1000);
      run_expiry(3, 32'h1C00);
      check_disp("rr_0_to_5", 3'd5, 32'h5A04);

      // 3: proc_end on the expiry tick wins; then drain to IDLE
      pc_in = 32'h5D00;
      tick  = 1'b1;
      step();
      step();
      proc_end = 1'b1;
      step();
      proc_end = 1'b0;
      tick     = 1'b0;
      check_eq("end_beats_expiry", 64'(preempt_req), 64'd0);
      wait_dispatch(4);
      check_disp("after_end5", 3'd7, 32'h7B04);
      proc_end = 1'b1;
      step();
      proc_end = 1'b0;
      wait_dispatch(4);
      check_disp("after_end7", 3'd0, 32'h1C04);
      proc_end = 1'b1;
      step();
      proc_end = 1'b0;
      check_eq("last_end_os_mode", 64'(os_mode), 64'd1);
      check_eq("last_end_preempt", 64'(preempt_req), 64'd0);
      step();
      step();
      check_eq("idle_no_dispatch", 64'(dispatch_vld), 64'd0);
      check_eq("idle_os_mode2", 64'(os_mode), 64'd1);

      // 4: quantum 0 disables preemption from the next dispatch on
      start_slot(3'd3, 32'h300);
      wait_dispatch(4);
      check_disp("pid3", 3'd3, 32'h300);
      set_quantum   = 1'b1;
      quantum_value = 32'd0;
      step();
      set_quantum = 1'b0;
      check_eq("no_rescale", 64'(quantum_left), 64'd3);
      run_expiry(3, 32'h3A00);
      check_disp("q0_dispatch", 3'd3, 32'h3A04);
      check_eq("q0_qleft", 64'(quantum_left), 64'd0);
      seen = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (preempt_req) seen = 1'b1;
      end
      tick = 1'b0;
      check_eq("q0_no_preempt", 64'(seen), 64'd0);
      check_eq("q0_qleft_stays", 64'(quantum_left), 64'd0);

      // 5: same-slot start+end keeps slot; halt freezes; async reset mid-SAVE
      set_quantum   = 1'b1;
      quantum_value = 32'd5;
      step();
      set_quantum = 1'b0;
      proc_end    = 1'b1;
      start_slot(3'd3, 32'h3330);
      proc_end = 1'b0;
      wait_dispatch(4);
      check_disp("start_wins", 3'd3, 32'h3330);
      check_eq("q5_qleft", 64'(quantum_left), 64'd5);
      tick = 1'b1;
      step();
      check_eq("tick_dec", 64'(quantum_left), 64'd4);
      halt = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check_eq("halt_frozen", 64'(quantum_left), 64'd4);
      check_eq("halt_no_preempt", 64'(preempt_req), 64'd0);
      halt = 1'b0;
      for (int i = 0; i < 4; i++) step();
      tick = 1'b0;
      check_eq("save_preempt", 64'(preempt_req), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("async_rst_preempt", 64'(preempt_req), 64'd0);
      check_eq("async_rst_os_mode", 64'(os_mode), 64'd1);
      step();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("post_rst_idle", 64'(os_mode), 64'd1);
      check_eq("post_rst_no_disp", 64'(dispatch_vld), 64'd0);

`ifdef QUANTUM_STATS_EN
      // 6: preemption statistics
      set_quantum   = 1'b1;
      quantum_value = 32'd2;
      start_slot(3'd1, 32'h10);
      set_quantum = 1'b0;
      wait_dispatch(4);
      for (int i = 0; i < 3; i++) run_expiry(2, 32'h40);
      stat_pid = 3'd1;
      #1;
      check_eq("stat_cnt3", 64'(stat_cnt), 64'd3);
      start_slot(3'd1, 32'h10);
      check_eq("stat_cleared", 64'(stat_cnt), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
